// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with hardwired zero register,
// write-to-read bypass and a per-register pending scoreboard used by ID for
// hazard detection. There is no valid/ready handshake on this block: every
// input is sampled on each rising clk edge and reads are purely combinational.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WbRegNum,
    input  logic [DATA_W-1:0]        WbData,
    input  logic [NUM_RD*ADDR_W-1:0] RdNum,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     IssueValid,
    input  logic [ADDR_W-1:0]        IssueRegNum,
    input  logic                     Flush,
    output logic [ADDR_W:0]          PendingCnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wr_en;
    logic              iss_en;

    // Register 0 is neither written nor reserved when hardwired to zero.
    assign wr_en  = RegWrite && !(ZR && (WbRegNum == '0));
    assign iss_en = IssueValid && !(ZR && (IssueRegNum == '0));

    // Scoreboard next state: flush clears everything, otherwise a reservation
    // overrides a same-cycle writeback to the same register.
    always_comb begin
        pend_nxt = pend;
        if (Flush) begin
            pend_nxt = '0;
        end else begin
            if (RegWrite) begin
                pend_nxt[WbRegNum] = 1'b0;
            end
            if (iss_en) begin
                pend_nxt[IssueRegNum] = 1'b1;
            end
        end
    end

    // Population count of the next pending vector, so the registered count
    // always matches pend after the same edge.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W + 1)'(pend_nxt[i]);
        end
    end

    // Register storage: async clear, posedge writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[WbRegNum] <= WbData;
        end
    end

    // Pending bits and their registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            PendingCnt <= '0;
        end else begin
            pend       <= pend_nxt;
            PendingCnt <= cnt_nxt;
        end
    end

    // Read ports: zero register first, then bypass of the in-flight
    // writeback, then stored value. Outputs are forced low while in reset so
    // a writeback presented during reset cannot leak through the bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] r;
        logic              is_zero;
        logic              is_byp;

        assign r       = RdNum[k*ADDR_W +: ADDR_W];
        assign is_zero = ZR && (r == '0);
        assign is_byp  = BP && RegWrite && (WbRegNum == r);

        assign RdData[k*DATA_W +: DATA_W] = (!rst_n || is_zero) ? '0 :
                                            is_byp ? WbData : mem[r];
        assign RdBusy[k] = rst_n && !is_zero && !is_byp && pend[r];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios followed by random traffic, checked
// against a behavioural model of the register file and scoreboard.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  WbRegNum;
    logic [31:0] WbData;
    logic [9:0]  RdNum;
    logic [63:0] RdData;
    logic [1:0]  RdBusy;
    logic        IssueValid;
    logic [4:0]  IssueRegNum;
    logic        Flush;
    logic [5:0]  PendingCnt;

    // Expected observation: {PendingCnt, RdBusy[1:0], RdData1, RdData0}.
    logic [71:0] exp_q[$];

    logic [31:0] model_mem [32];
    logic [31:0] model_pend;

    int checks;
    int errors;

    regfile_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RegWrite(RegWrite),
        .WbRegNum(WbRegNum),
        .WbData(WbData),
        .RdNum(RdNum),
        .RdData(RdData),
        .RdBusy(RdBusy),
        .IssueValid(IssueValid),
        .IssueRegNum(IssueRegNum),
        .Flush(Flush),
        .PendingCnt(PendingCnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        model_pend = '0;
    endtask

    function automatic logic [5:0] model_cnt();
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(model_pend[i]);
        return c;
    endfunction

    // Expected combinational read of one port given current inputs.
    task automatic model_read(input logic [4:0] r, output logic [31:0] d, output logic b);
        if (!rst_n || r == 5'd0) begin
            d = '0; b = 1'b0;
        end else if (RegWrite && WbRegNum == r) begin
            d = WbData; b = 1'b0;
        end else begin
            d = model_mem[r]; b = model_pend[r];
        end
    endtask

    task automatic push_expect();
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [5:0]  c;
        model_read(RdNum[4:0], d0, b0);
        model_read(RdNum[9:5], d1, b1);
        c = rst_n ? model_cnt() : 6'd0;
        exp_q.push_back({c, b1, b0, d1, d0});
    endtask

    task automatic observe();
        logic [71:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: expected queue empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("rd0_data", RdData[31:0], e[31:0]);
            check("rd1_data", RdData[63:32], e[63:32]);
            check("rd0_busy", 32'(RdBusy[0]), 32'(e[64]));
            check("rd1_busy", 32'(RdBusy[1]), 32'(e[65]));
            check("pend_cnt", 32'(PendingCnt), 32'(e[71:66]));
        end
    endtask

    // Model state update on a rising edge, from the inputs the DUT samples.
    task automatic model_update();
        if (!rst_n) return;
        if (RegWrite && WbRegNum != 5'd0) model_mem[WbRegNum] = WbData;
        if (Flush) begin
            model_pend = '0;
        end else begin
            if (RegWrite) model_pend[WbRegNum] = 1'b0;
            if (IssueValid && IssueRegNum != 5'd0) model_pend[IssueRegNum] = 1'b1;
        end
    endtask

    // Driver
    task automatic drive(input logic we, input logic [4:0] wb, input logic [31:0] wd,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic iv, input logic [4:0] ir, input logic fl);
        RegWrite    = we;
        WbRegNum    = wb;
        WbData      = wd;
        RdNum       = {r1, r0};
        IssueValid  = iv;
        IssueRegNum = ir;
        Flush       = fl;
    endtask

    // One cycle: check outputs at negedge, then advance model at posedge.
    task automatic step();
        @(negedge clk);
        push_expect();
        observe();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        model_reset();
        // Reset held with a writeback pending: outputs must stay zero.
        drive(1'b1, 5'd5, 32'h1111_2222, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        step();

        // 1. All registers read zero and idle after reset.
        for (int r = 0; r < 32; r++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(r), 5'(31 - r), 1'b0, 5'd0, 1'b0);
            step();
        end

        // 2. Write r5 with same-cycle bypass, then stored value.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 1'b0, 5'd0, 1'b0);
        step();

        // 3. Zero register ignores write and reservation.
        drive(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();

        // 4. Issue r3, issue r7, writeback r3.
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, 5'd3, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0);
        step();
        drive(1'b1, 5'd3, 32'h3333_0003, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b1, 5'd7, 32'h7777_0007, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0);
        step();

        // 5. Reserve and writeback r9 together: reserve wins, data written.
        drive(1'b1, 5'd9, 32'h0000_00A5, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd3, 1'b0, 5'd0, 1'b0);
        step();

        // 6. Pend r1..r4, then flush alongside an issue to r6.
        for (int r = 1; r <= 4; r++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(r), 5'd9, 1'b1, 5'(r), 1'b0);
            step();
        end
        drive(1'b1, 5'd12, 32'hC0FF_EE12, 5'd6, 5'd2, 1'b1, 5'd6, 1'b1);
        step();
        drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd12, 1'b0, 5'd0, 1'b0);
        step();

        // Mid-cycle asynchronous reset with stored data present.
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b1, 5'd8, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_expect();
        observe();
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0);
        step();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 19) == 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
